// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL dynamic-reconfiguration controller:
// FSM state encoding and the bundled PLL select values.
package pll_ctrl_pkg;

  localparam int SEL_W = 6;
  localparam int PS_W  = 4;

  typedef enum logic [2:0] {
    ST_APPLY     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] idsel;
    logic [SEL_W-1:0] fbdsel;
    logic [SEL_W-1:0] odsel;
    logic [PS_W-1:0]  psda;
    logic [PS_W-1:0]  dutyda;
  } pll_sel_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock
// into the crystal clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL dynamic-configuration controller: applies select values,
// pulses PLL reset, qualifies lock with timeout/retry.
module pll_dyn_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned      RST_CYCLES   = 16,
  parameter int unsigned      LOCK_TIMEOUT = 65535,
  parameter int unsigned      LOCK_STABLE  = 1024,
  parameter int unsigned      MAX_RETRY    = 3,
  parameter logic [SEL_W-1:0] DEF_IDSEL    = '0,
  parameter logic [SEL_W-1:0] DEF_FBDSEL   = '0,
  parameter logic [SEL_W-1:0] DEF_ODSEL    = '0,
  parameter logic [PS_W-1:0]  DEF_PSDA     = '0,
  parameter logic [PS_W-1:0]  DEF_DUTYDA   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_req,
  input  logic [SEL_W-1:0] cfg_idsel,
  input  logic [SEL_W-1:0] cfg_fbdsel,
  input  logic [SEL_W-1:0] cfg_odsel,
  input  logic [PS_W-1:0]  cfg_psda,
  input  logic [PS_W-1:0]  cfg_dutyda,
  output logic             cfg_ack,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             pll_reset_p,
  output logic [SEL_W-1:0] pll_idsel,
  output logic [SEL_W-1:0] pll_fbdsel,
  output logic [SEL_W-1:0] pll_odsel,
  output logic [PS_W-1:0]  pll_psda,
  output logic [PS_W-1:0]  pll_dutyda,
  output logic             locked,
  output logic             user_rst_n,
  output logic             fail
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int NW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [NW-1:0] RTY_MAX  = NW'(MAX_RETRY);

  localparam pll_sel_t DEF_SEL = pll_sel_t'({DEF_IDSEL, DEF_FBDSEL,
    DEF_ODSEL, DEF_PSDA, DEF_DUTYDA});

  state_e        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0] stb_cnt_q, stb_cnt_d;
  logic [NW-1:0] retry_q, retry_d;
  pll_sel_t      sel_q, sel_d;
  logic          ack_q, ack_d;
  logic          prst_q, prst_d;
  logic          run_q, run_d;
  logic          fail_q, fail_d;
  logic          lock_s;
  logic          accept;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Counters only advance below their terminal value, so they cannot wrap.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    tmo_cnt_d = '0;
    stb_cnt_d = '0;
    retry_d   = retry_q;
    sel_d     = sel_q;
    ack_d     = 1'b0;
    accept    = cfg_req && (state_q == ST_RUN || state_q == ST_FAIL);
    unique case (state_q)
      ST_APPLY: begin
        if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else rst_cnt_d = rst_cnt_q + RW'(1);
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + NW'(1);
            state_d = ST_APPLY;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) state_d = ST_WAIT_LOCK;
        else if (stb_cnt_q == STB_LAST) state_d = ST_RUN;
        else stb_cnt_d = stb_cnt_q + SW'(1);
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_APPLY;
          retry_d = '0;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_APPLY;
    endcase
    if (accept) begin
      state_d = ST_APPLY;
      retry_d = '0;
      ack_d   = 1'b1;
      sel_d   = pll_sel_t'({cfg_idsel, cfg_fbdsel, cfg_odsel,
                            cfg_psda, cfg_dutyda});
    end
    prst_d = (state_d == ST_APPLY) || (state_d == ST_FAIL);
    run_d  = (state_d == ST_RUN);
    fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_APPLY;
      rst_cnt_q <= '0;
      tmo_cnt_q <= '0;
      stb_cnt_q <= '0;
      retry_q   <= '0;
      sel_q     <= DEF_SEL;
      ack_q     <= 1'b0;
      prst_q    <= 1'b1;
      run_q     <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      retry_q   <= retry_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      prst_q    <= prst_d;
      run_q     <= run_d;
      fail_q    <= fail_d;
    end
  end

  assign cfg_ack     = ack_q;
  assign pll_reset   = prst_q;
  assign pll_reset_p = prst_q;
  assign pll_idsel   = sel_q.idsel;
  assign pll_fbdsel  = sel_q.fbdsel;
  assign pll_odsel   = sel_q.odsel;
  assign pll_psda    = sel_q.psda;
  assign pll_dutyda  = sel_q.dutyda;
  assign locked      = run_q;
  assign user_rst_n  = run_q;
  assign fail        = fail_q;

endmodule

// File: doc/pll_dyn_ctrl.md
PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of clk cycles the PLL reset is held per apply.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: number of clk cycles to wait for lock before a retry.
REQ-003 SHALL have parameter LOCK_STABLE, default 1024: number of consecutive synced-lock-high cycles required to declare lock.
REQ-004 SHALL have parameter MAX_RETRY, default 3: number of retries after the first attempt before failing.
REQ-005 SHALL have parameters DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL (6b each) and DEF_PSDA, DEF_DUTYDA (4b each), all defaulting to 0: the configuration applied after reset.
REQ-006 SHALL have port clk, input, 1: free-running crystal clock; never a PLL output.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port cfg_req, input, 1: level request for a new configuration; the requester holds it until cfg_ack.
REQ-009 SHALL have ports cfg_idsel, cfg_fbdsel, cfg_odsel (input, 6 each) and cfg_psda, cfg_dutyda (input, 4 each): raw PLL dynamic select values, already in device encoding.
REQ-010 SHALL have port cfg_ack, output, 1: one-cycle pulse when a request is accepted.
REQ-011 SHALL have port pll_lock, input, 1: PLL LOCK, asynchronous to clk.
REQ-012 SHALL have ports pll_reset and pll_reset_p, output, 1 each: drive the PLL RESET and RESET_P pins.
REQ-013 SHALL have ports pll_idsel, pll_fbdsel, pll_odsel (output, 6 each) and pll_psda, pll_dutyda (output, 4 each): drive the PLL dynamic select pins.
REQ-014 SHALL have ports locked and user_rst_n, output, 1 each: stable-lock flag and downstream active-low reset.
REQ-015 SHALL have port fail, output, 1: set when retries are exhausted.

Function
REQ-016 SHALL pass pll_lock through a 2-FF synchronizer; all lock decisions use the synced value only.
REQ-017 SHALL implement states APPLY, WAIT_LOCK, STABLE, RUN and FAIL.
REQ-018 APPLY: pll_reset and pll_reset_p SHALL be 1; after RST_CYCLES cycles the state SHALL go to WAIT_LOCK.
REQ-019 WAIT_LOCK: the timer SHALL restart on entry; synced lock = 1 SHALL go to STABLE.
REQ-020 WAIT_LOCK: if the timer reaches LOCK_TIMEOUT and retry_cnt < MAX_RETRY, SHALL increment retry_cnt and go to APPLY; otherwise SHALL go to FAIL.
REQ-021 STABLE: the counter SHALL count synced-lock-high cycles; lock = 0 SHALL go to WAIT_LOCK with the timer restarted, with no retry consumed.
REQ-022 STABLE: reaching LOCK_STABLE SHALL go to RUN; latency from a clean pll_lock rise to locked = 1 SHALL be LOCK_STABLE+3 clk cycles.
REQ-023 RUN: locked and user_rst_n SHALL be 1; synced lock = 0 SHALL go to APPLY with the same config and retry_cnt cleared.
REQ-024 FAIL: fail SHALL be 1 and pll_reset SHALL be 1; the state SHALL be left only via cfg_req or rst_n.
REQ-025 cfg_req SHALL be accepted only in RUN or FAIL.
REQ-026 On acceptance: the cfg_* values SHALL be latched into the pll_* registers, cfg_ack SHALL pulse 1 cycle, retry_cnt SHALL clear, fail SHALL clear, and the state SHALL go to APPLY.
REQ-027 cfg_req asserted in any other state SHALL stay pending and SHALL be accepted on the first cycle in RUN or FAIL.
REQ-028 pll_* select outputs SHALL change only on cfg_ack cycles or on reset, so they are stable while pll_reset is low.
REQ-029 locked and user_rst_n SHALL be registered and SHALL be 0 in every state except RUN.
REQ-030 pll_reset SHALL be 1 in APPLY and FAIL, and 0 in WAIT_LOCK, STABLE and RUN.
REQ-031 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-032 rst_n low SHALL asynchronously force: state = APPLY, pll_reset = pll_reset_p = 1, pll_* = DEF_*, locked = 0, user_rst_n = 0, fail = 0, cfg_ack = 0, all counters = 0, synchronizer = 0.
REQ-033 rst_n asserted mid-operation (any state) SHALL abandon that operation, including a pending cfg_req, and SHALL restart from APPLY with the defaults.

Structure
REQ-034 The state encoding and select-width constants SHALL live in a shared package pll_ctrl_pkg.
REQ-035 The lock synchronizer SHALL be one sub-module, sync_2ff.
REQ-036 The block SHALL instantiate no PLL; the top level connects it to the PLL wrapper's dynamic ports, with the wrapper's DYN_*_SEL parameters set to "true".

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRY=2)
REQ-037 Release rst_n; raise pll_lock 10 cycles after pll_reset falls -> pll_reset high for exactly 4 cycles, locked = user_rst_n = 1 exactly 11 cycles after the lock rise.
REQ-038 Hold pll_lock = 0 -> exactly 3 pll_reset pulses of 4 cycles each, 32 cycles apart, then fail = 1 with pll_reset held high.
REQ-039 Glitch pll_lock low for 3 cycles during STABLE -> no retry, locked asserts 11 cycles after the final rise.
REQ-040 In RUN, drop pll_lock -> user_rst_n = 0 within 3 cycles, pll_reset re-pulses, pll_* values unchanged.
REQ-041 In RUN, cfg_req with cfg_idsel = 6'd60 and cfg_odsel = 6'd56 -> one-cycle cfg_ack, pll_idsel = 60 and pll_odsel = 56 on the same edge pll_reset rises; a cfg_req issued during WAIT_LOCK is acked only after RUN.
REQ-042 Assert rst_n mid WAIT_LOCK with a pending cfg_req -> all outputs at reset values immediately, DEF_* restored, and no cfg_ack.
